// File: rtl/arm_mem_pkg.sv
// Shared types, default widths and helper functions for the MEM-stage SRAM controller.
package arm_mem_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_SRAM_DW   = 16;
    localparam int DEF_SRAM_AW   = 18;
    localparam int DEF_WAIT_CYC  = 2;
    localparam int DEF_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int calc_beats(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

    function automatic int calc_byte_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Per-beat wait-state counter: counts 0..MAX, wraps to 0 after the terminal count.
module sram_wait_timer #(
    parameter int W   = 2,
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle MEM-stage controller: one DATA_W load/store split into SRAM_DW beats with wait states.
// Optional one-entry last-read bypass buffer enabled by defining SRAM_LAST_RD_BYPASS_EN.
module sram_mem_ctrl
    import arm_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SRAM_DW   = DEF_SRAM_DW,
    parameter int SRAM_AW   = DEF_SRAM_AW,
    parameter int WAIT_CYC  = DEF_WAIT_CYC,
    parameter int BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output state_t             dbg_state
);

    localparam int BEATS = calc_beats(DATA_W, SRAM_DW);
    localparam int SHIFT = calc_byte_shift(DATA_W);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              timer_clr, timer_en, wait_tc, last_beat;
    logic [DATA_W-1:0] word_idx, lin_addr;

    sram_wait_timer #(.W(CW), .MAX(WAIT_CYC)) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (timer_clr),
        .en_i  (timer_en),
        .tc_o  (wait_tc)
    );

    // Address arithmetic is modulo 2^DATA_W; the SRAM address silently wraps.
    assign word_idx  = (addr_q - DATA_W'(BASE_ADDR)) >> SHIFT;
    assign lin_addr  = word_idx * DATA_W'(BEATS) + DATA_W'(beat_q);
    assign last_beat = (beat_q == BW'(BEATS - 1));

    assign ready     = !((rd_en | wr_en) && (state_q != DONE));
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

`ifdef SRAM_LAST_RD_BYPASS_EN
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] buf_word_q, buf_word_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [DATA_W-1:0] in_word;
    logic              buf_hit;

    assign in_word = (addr - DATA_W'(BASE_ADDR)) >> SHIFT;
    assign buf_hit = buf_valid_q && (in_word == buf_word_q);

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_word_d  = buf_word_q;
        buf_data_d  = buf_data_q;
        if (state_q == IDLE && wr_en && in_word == buf_word_q) begin
            buf_data_d = wdata;
        end
        if (state_q == ACCESS && !op_wr_q && wait_tc && last_beat) begin
            buf_valid_d = 1'b1;
            buf_word_d  = word_idx;
            buf_data_d  = rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_word_q  <= buf_word_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_wr_d     = op_wr_q;
        rdata_d     = rdata_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (rd_en | wr_en) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_wr_d = wr_en;
                    beat_d  = '0;
                    state_d = ACCESS;
`ifdef SRAM_LAST_RD_BYPASS_EN
                    if (!wr_en && buf_hit) begin
                        state_d = DONE;
                        rdata_d = buf_data_q;
                    end
`endif
                end
            end
            ACCESS: begin
                timer_en  = 1'b1;
                sram_addr = lin_addr[SRAM_AW-1:0];
                if (op_wr_q) begin
                    sram_dq_out = wdata_q[int'(beat_q)*SRAM_DW +: SRAM_DW];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (wait_tc) begin
                    if (!op_wr_q) begin
                        rdata_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = sram_dq_in;
                    end
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: directed cases plus random loads/stores against a word-level model.
`timescale 1ns/1ps
module tb_sram_mem_ctrl;
  import arm_mem_pkg::*;

  localparam int AW    = 18;
  localparam int BASE  = 1024;
  localparam int WC    = 2;
  localparam int BEATS = 2;
`ifdef SRAM_LAST_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // default-parameter DUT
  logic          rd_en, wr_en, ready, dq_oe, we_n;
  logic [31:0]   addr, wdata, rdata;
  logic [AW-1:0] sram_addr;
  logic [15:0]   dq_out, dq_in;
  state_t        dbg_state;

  // 8-bit, zero-wait DUT
  logic          rd8, wr8, ready8, dq_oe8, we_n8;
  logic [31:0]   addr8, wdata8, rdata8;
  logic [AW-1:0] sram_addr8;
  logic [7:0]    dq_out8, dq_in8;
  state_t        dbg_state8;

  sram_mem_ctrl dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out),
    .sram_dq_oe(dq_oe), .sram_dq_in(dq_in), .sram_we_n(we_n), .dbg_state(dbg_state)
  );

  sram_mem_ctrl #(.SRAM_DW(8), .WAIT_CYC(0)) dut8 (
    .clk(clk), .rst(rst), .rd_en(rd8), .wr_en(wr8), .addr(addr8), .wdata(wdata8),
    .rdata(rdata8), .ready(ready8), .sram_addr(sram_addr8), .sram_dq_out(dq_out8),
    .sram_dq_oe(dq_oe8), .sram_dq_in(dq_in8), .sram_we_n(we_n8), .dbg_state(dbg_state8)
  );

  function automatic logic [15:0] pat16(input int a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [7:0] pat8(input int a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // SRAM models: asynchronous read, write while we_n is low (sampled mid-cycle)
  logic [15:0] sram16 [0:(1<<AW)-1];
  logic [7:0]  sram8  [0:(1<<AW)-1];
  assign dq_in  = sram16[sram_addr];
  assign dq_in8 = sram8[sram_addr8];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram16[i] = pat16(i);
      sram8[i]  = pat8(i);
    end
    forever begin
      @(negedge clk);
      if (!we_n)  sram16[sram_addr]  <= dq_out;
      if (!we_n8) sram8[sram_addr8]  <= dq_out8;
    end
  end

  // scoreboard counters and checker
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // reference model: word contents keyed by the SRAM address of beat 0
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = '0;
  bit          bvalid  = 1'b0;
  logic [31:0] bword   = '0;
  logic [31:0] bdata   = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a - 32'(BASE)) / 4;
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    logic [31:0] s;
    s = word_of(a) * 32'(BEATS);
    return int'(s % (1 << AW));
  endfunction

  function automatic logic [31:0] ref_read(input int slot);
    if (ref_mem.exists(slot)) return ref_mem[slot];
    return {pat16(slot + 1), pat16(slot)};
  endfunction

  // idle cycles with no request: everything quiet, rdata holding
  task automatic idle_check(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle_ready", ready, 1);
      check("idle_state", dbg_state, IDLE);
      check("idle_we_n", we_n, 1);
      check("idle_oe", dq_oe, 0);
      check("idle_rdata", rdata, last_rd);
    end
  endtask

  // driver: called at a negedge where the DUT is IDLE; that cycle is cycle 0
  task automatic run_txn(input bit do_wr, input bit do_rd, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, exp_rd;
    int slot, lat, b;
    bit hit;
    w      = word_of(a);
    slot   = slot_of(a);
    hit    = BYP && !do_wr && bvalid && (bword == w);
    lat    = hit ? 1 : 1 + BEATS * (WC + 1);
    exp_rd = hit ? bdata : ref_read(slot);
    rd_en = do_rd; wr_en = do_wr; addr = a; wdata = wd;
    #1;
    check("c0_ready", ready, 0);
    check("c0_state", dbg_state, IDLE);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n < lat) begin
        b = (n - 1) / (WC + 1);
        check($sformatf("c%0d_ready", n), ready, 0);
        check($sformatf("c%0d_state", n), dbg_state, ACCESS);
        check($sformatf("c%0d_saddr", n), sram_addr, (slot + b) % (1 << AW));
        check($sformatf("c%0d_we_n", n), we_n, !do_wr);
        check($sformatf("c%0d_oe", n), dq_oe, do_wr);
        if (do_wr) check($sformatf("c%0d_dq", n), dq_out, wd[b*16 +: 16]);
        addr  = $urandom;
        wdata = $urandom;
      end else begin
        check("done_ready", ready, 1);
        check("done_state", dbg_state, DONE);
        check("done_we_n", we_n, 1);
        check("done_oe", dq_oe, 0);
        check("done_rdata", rdata, do_wr ? last_rd : exp_rd);
        if (hit) check("hit_saddr", sram_addr, 0);
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    if (do_wr) begin
      ref_mem[slot] = wd;
      if (bword == w) bdata = wd;
    end else begin
      last_rd = exp_rd;
      if (BYP && !hit) begin
        bvalid = 1'b1; bword = w; bdata = exp_rd;
      end
    end
  endtask

  // both enables set, reset lands at the end of cycle 3 (first beat, wait 2)
  task automatic reset_mid_write(input logic [31:0] a, input logic [31:0] wd);
    int slot;
    logic [31:0] old;
    slot = slot_of(a);
    old  = ref_read(slot);
    rd_en = 1'b1; wr_en = 1'b1; addr = a; wdata = wd;
    #1;
    check("rm_c0_ready", ready, 0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check($sformatf("rm_c%0d_we_n", n), we_n, 0);
      check($sformatf("rm_c%0d_saddr", n), sram_addr, slot);
      check($sformatf("rm_c%0d_dq", n), dq_out, wd[15:0]);
    end
    rst = 1'b0;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    check("rm_state", dbg_state, IDLE);
    check("rm_we_n", we_n, 1);
    check("rm_oe", dq_oe, 0);
    check("rm_rdata", rdata, 0);
    check("rm_saddr", sram_addr, 0);
    check("rm_ready", ready, 1);
    rst = 1'b1;
    ref_mem[slot] = {old[31:16], wd[15:0]};
    last_rd = '0;
    bvalid  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rd_en = 1'b0; wr_en = 1'b1; addr = 32'd1024; wdata = 32'hDEADBEEF;
    rd8 = 1'b0; wr8 = 1'b0; addr8 = '0; wdata8 = '0;

    // reset held 3 cycles with a store pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_we_n", we_n, 1);
      check("rst_ready", ready, 0);
      check("rst_state", dbg_state, IDLE);
      check("rst_rdata", rdata, 0);
      check("rst_saddr", sram_addr, 0);
      check("rst_dq", dq_out, 0);
      check("rst_oe", dq_oe, 0);
    end
    rst = 1'b1;
    run_txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);

    idle_check(1); run_txn(1'b0, 1'b1, 32'd1024, 32'h0);
    idle_check(1); run_txn(1'b0, 1'b1, 32'd1024, 32'h0);
    idle_check(1); run_txn(1'b1, 1'b0, 32'd1024, 32'h12345678);
    idle_check(1); run_txn(1'b0, 1'b1, 32'd1024, 32'h0);
    idle_check(1); run_txn(1'b0, 1'b1, 32'd1028, 32'h0);
    idle_check(1); run_txn(1'b0, 1'b1, 32'd0, 32'h0);
    idle_check(1); run_txn(1'b0, 1'b1, 32'd1027, 32'h0);

    idle_check(1); reset_mid_write(32'd1036, 32'hCAFEF00D);
    run_txn(1'b0, 1'b1, 32'd1036, 32'h0);

    // random mix of loads, stores and combined requests over a small window
    for (int t = 0; t < 40; t++) begin
      int op;
      logic [31:0] a, d;
      op = $urandom_range(0, 2);
      a  = 32'(BASE) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      d  = $urandom;
      idle_check(1 + $urandom_range(0, 2));
      run_txn(op != 0, op != 1, a, d);
    end

    // 8-bit SRAM, no wait states: 4 beats, ready at cycle 5
    idle_check(1);
    rd8 = 1'b1; addr8 = 32'd1032;
    #1;
    check("d8_c0_ready", ready8, 0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n < 5) begin
        check($sformatf("d8_c%0d_ready", n), ready8, 0);
        check($sformatf("d8_c%0d_saddr", n), sram_addr8, 32'(8 + n - 1));
        check($sformatf("d8_c%0d_we_n", n), we_n8, 1);
      end else begin
        check("d8_done_ready", ready8, 1);
        check("d8_rdata", rdata8, {pat8(11), pat8(10), pat8(9), pat8(8)});
      end
    end
    rd8 = 1'b0;
    @(negedge clk);
    check("d8_idle_state", dbg_state8, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
